mux_nto1_skid: RTL and testbench

- Parametrised N-to-1 WIDTH-bit selector with a registered output and a valid/ready handshake on both sides.
- Includes a one-entry skid buffer, so in_ready is driven from a register and never combinationally from out_ready.
- Used where a selected operand must cross a stall boundary intact, e.g. divider/multiplier operand selection and Hi/Lo write-back.
- Generalises the fixed 2-input 32-bit combinational selectors in the datapath.

---
 rtl/mux_nto1_skid_pkg.sv | 21 ++
 rtl/mux_nto1_comb.sv | 39 +++
 rtl/mux_nto1_skid.sv | 132 +++++++++++++
 tb/tb_mux_nto1_skid.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_nto1_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_skid_pkg
// Description : Shared definitions for the N-to-1 selector with skid buffer:
//               handshake state encoding and channel-count limits.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_nto1_skid_pkg;

  // Occupancy of the two holding registers (main, skid).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,   // main empty, skid empty
    FULL  = 2'd1,   // main occupied, skid empty
    SKID  = 2'd2    // main and skid occupied
  } state_t;

  localparam int NUM_IN_MIN = 2;
  localparam int NUM_IN_MAX = 16;

endpackage : mux_nto1_skid_pkg
`default_nettype wire

// File: rtl/mux_nto1_comb.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_comb
// Description : Purely combinational indexed select with range check.
//               sel < NUM_IN  -> data = channel sel, err = 0
//               sel >= NUM_IN -> data = RESET_VAL,   err = 1
// Ports       : in_bus [NUM_IN*WIDTH] packed channels (channel k at k*WIDTH)
//               sel    [SEL_W]        channel index
//               data   [WIDTH]        selected value
//               err                   index out of range
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1_comb #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_IN    = 4,
  parameter int               SEL_W     = $clog2(NUM_IN),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        data,
  output logic                    err
);

  // Out-of-range selects (only possible when NUM_IN is not a power of two)
  // fall through to the defaults.
  always_comb begin
    data = RESET_VAL;
    err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) begin
        data = in_bus[k*WIDTH +: WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule : mux_nto1_comb
`default_nettype wire

// File: rtl/mux_nto1_skid.sv
`default_nettype none
// ============================================================================
// Module      : mux_nto1_skid
// Description : N-to-1 WIDTH-bit selector with registered output, valid/ready
//               handshake on both sides and a one-entry skid buffer so that
//               in_ready is a register, never a combinational function of
//               out_ready.
// Ports       : clk, reset (sync, active-high)
//               in_bus/sel/in_valid/in_ready  producer side
//               flush                         discard all held entries
//               out_data/out_sel/out_err/out_valid/out_ready  consumer side
// Revision    : 1.0 - initial release
// ============================================================================
module mux_nto1_skid
  import mux_nto1_skid_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NUM_IN    = 4,
  parameter int               SEL_W     = $clog2(NUM_IN),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  generate
    if (NUM_IN < NUM_IN_MIN || NUM_IN > NUM_IN_MAX) begin : g_bad_num_in
      $fatal(1, "mux_nto1_skid: NUM_IN=%0d outside legal range 2..16", NUM_IN);
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_skid_data;
  logic [SEL_W-1:0] r_skid_sel;
  logic             r_skid_err;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;
  logic             w_accept;
  logic             w_pop;

  mux_nto1_comb #(
    .WIDTH     (WIDTH),
    .NUM_IN    (NUM_IN),
    .SEL_W     (SEL_W),
    .RESET_VAL (RESET_VAL)
  ) u_sel (
    .in_bus (in_bus),
    .sel    (sel),
    .data   (w_sel_data),
    .err    (w_sel_err)
  );

  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign out_valid = (r_state != EMPTY);

  // Main register (out_*) always holds the oldest entry; the skid register
  // only absorbs the one extra beat accepted while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= EMPTY;
      in_ready    <= 1'b1;
      out_data    <= RESET_VAL;
      out_sel     <= '0;
      out_err     <= 1'b0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
      r_skid_err  <= 1'b0;
    end else if (flush) begin
      // Output registers keep their contents; only occupancy is dropped.
      r_state  <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (w_accept) begin
            out_data <= w_sel_data;
            out_sel  <= sel;
            out_err  <= w_sel_err;
            r_state  <= FULL;
          end
        end
        FULL: begin
          in_ready <= 1'b1;
          if (w_accept && w_pop) begin
            out_data <= w_sel_data;
            out_sel  <= sel;
            out_err  <= w_sel_err;
          end else if (w_accept) begin
            r_skid_data <= w_sel_data;
            r_skid_sel  <= sel;
            r_skid_err  <= w_sel_err;
            r_state     <= SKID;
            in_ready    <= 1'b0;
          end else if (w_pop) begin
            r_state <= EMPTY;
          end
        end
        SKID: begin
          // in_ready is low here, so no accept can coincide with the pop.
          if (w_pop) begin
            out_data <= r_skid_data;
            out_sel  <= r_skid_sel;
            out_err  <= r_skid_err;
            r_state  <= FULL;
            in_ready <= 1'b1;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          r_state  <= EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule : mux_nto1_skid
`default_nettype wire

// File: tb/tb_mux_nto1_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_nto1_skid
// Description : Self-checking bench for mux_nto1_skid. Two instances
//               (NUM_IN=4 and NUM_IN=3) are compared every cycle against a
//               two-entry FIFO reference model, with directed scenarios
//               followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_nto1_skid;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
    logic        e;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic [127:0] bus;

  logic        a_valid, a_ready, a_out_ready, a_out_valid, a_err;
  logic [1:0]  a_sel, a_out_sel;
  logic [31:0] a_data;
  logic        b_valid, b_ready, b_out_ready, b_out_valid, b_err;
  logic [1:0]  b_sel, b_out_sel;
  logic [31:0] b_data;

  ent_t qa[$];
  ent_t qb[$];
  int   passed = 0;
  int   total  = 0;

  logic [31:0] words [4];

  always #5 clk = ~clk;

  mux_nto1_skid #(.WIDTH(32), .NUM_IN(4)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_bus    (bus),
    .sel       (a_sel),
    .in_valid  (a_valid),
    .in_ready  (a_ready),
    .flush     (flush),
    .out_data  (a_data),
    .out_sel   (a_out_sel),
    .out_err   (a_err),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready)
  );

  mux_nto1_skid #(.WIDTH(32), .NUM_IN(3)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_bus    (bus[95:0]),
    .sel       (b_sel),
    .in_valid  (b_valid),
    .in_ready  (b_ready),
    .flush     (flush),
    .out_data  (b_data),
    .out_sel   (b_out_sel),
    .out_err   (b_err),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Value a transfer carries: chosen channel, or zero with err for a bad index.
  function automatic ent_t ref_sel(input logic [127:0] b, input logic [1:0] s, input int n);
    ent_t e;
    e.s = s;
    if (int'(s) < n) begin
      e.d = b[int'(s)*32 +: 32];
      e.e = 1'b0;
    end else begin
      e.d = 32'h0;
      e.e = 1'b1;
    end
    return e;
  endfunction

  // One clock: compare both DUTs with the model at the falling edge, then
  // apply the cycle's transfers to the model at the rising edge.
  task automatic cycle();
    bit   acc_a, pop_a, acc_b, pop_b;
    ent_t ea, eb;
    @(negedge clk);
    chk("A.in_ready", a_ready, qa.size() < 2);
    chk("A.out_valid", a_out_valid, qa.size() != 0);
    if (qa.size() != 0) begin
      chk("A.out_data", a_data, qa[0].d);
      chk("A.out_sel", a_out_sel, qa[0].s);
      chk("A.out_err", a_err, qa[0].e);
    end
    chk("B.in_ready", b_ready, qb.size() < 2);
    chk("B.out_valid", b_out_valid, qb.size() != 0);
    if (qb.size() != 0) begin
      chk("B.out_data", b_data, qb[0].d);
      chk("B.out_sel", b_out_sel, qb[0].s);
      chk("B.out_err", b_err, qb[0].e);
    end
    acc_a = a_valid && (qa.size() < 2);
    pop_a = (qa.size() != 0) && a_out_ready;
    acc_b = b_valid && (qb.size() < 2);
    pop_b = (qb.size() != 0) && b_out_ready;
    ea = ref_sel(bus, a_sel, 4);
    eb = ref_sel(bus, b_sel, 3);
    @(posedge clk);
    if (reset || flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pop_a) void'(qa.pop_front());
      if (acc_a) qa.push_back(ea);
      if (pop_b) void'(qb.pop_front());
      if (acc_b) qb.push_back(eb);
    end
    #1;
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    words[0] = 32'hAAAA_0000;
    words[1] = 32'hBBBB_0001;
    words[2] = 32'hCCCC_0002;
    words[3] = 32'hDDDD_0003;
    bus = {words[3], words[2], words[1], words[0]};
    reset = 1'b1; flush = 1'b0;
    a_valid = 1'b0; a_sel = 2'd0; a_out_ready = 1'b0;
    b_valid = 1'b0; b_sel = 2'd0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    qa.delete();
    qb.delete();
    reset = 1'b0;

    // Reset release
    chk("rst.in_ready", a_ready, 1'b1);
    chk("rst.out_valid", a_out_valid, 1'b0);
    chk("rst.out_data", a_data, 32'h0);

    // Single transfer, one-cycle latency
    a_sel = 2'd2; a_valid = 1'b1;
    cycle();
    a_valid = 1'b0;
    chk("lat.out_valid", a_out_valid, 1'b1);
    chk("lat.out_data", a_data, 32'hCCCC_0002);
    chk("lat.out_sel", a_out_sel, 2'd2);
    chk("lat.out_err", a_err, 1'b0);
    a_out_ready = 1'b1;
    cycle();

    // Streaming at one transfer per cycle
    a_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_sel = 2'(i);
      cycle();
      chk("stream.out_data", a_data, words[i]);
      chk("stream.in_ready", a_ready, 1'b1);
    end
    a_valid = 1'b0;
    cycle();

    // Backpressure into the skid register
    a_out_ready = 1'b0;
    a_valid = 1'b1; a_sel = 2'd1;
    cycle();
    a_sel = 2'd3;
    cycle();
    a_valid = 1'b0;
    chk("bp.in_ready", a_ready, 1'b0);
    chk("bp.out_data", a_data, 32'hBBBB_0001);
    cycle();
    chk("bp.hold_data", a_data, 32'hBBBB_0001);
    a_out_ready = 1'b1;
    cycle();
    chk("bp.drain_data", a_data, 32'hDDDD_0003);
    chk("bp.ready_back", a_ready, 1'b1);
    cycle();
    chk("bp.empty", a_out_valid, 1'b0);

    // Out-of-range select on the 3-input instance
    b_out_ready = 1'b1; b_valid = 1'b1; b_sel = 2'd3;
    cycle();
    chk("oor.out_err", b_err, 1'b1);
    chk("oor.out_data", b_data, 32'h0);
    chk("oor.out_sel", b_out_sel, 2'd3);
    b_sel = 2'd0;
    cycle();
    chk("oor.next_err", b_err, 1'b0);
    chk("oor.next_data", b_data, 32'hAAAA_0000);
    b_valid = 1'b0;
    cycle();

    // Flush while in SKID with an input offered
    a_out_ready = 1'b0;
    a_valid = 1'b1; a_sel = 2'd0;
    cycle();
    a_sel = 2'd1;
    cycle();
    a_sel = 2'd2; flush = 1'b1;
    cycle();
    flush = 1'b0; a_valid = 1'b0;
    chk("flush.out_valid", a_out_valid, 1'b0);
    chk("flush.in_ready", a_ready, 1'b1);
    a_out_ready = 1'b1;
    repeat (2) cycle();
    chk("flush.no_output", a_out_valid, 1'b0);

    // Reset while in SKID under backpressure
    a_out_ready = 1'b0;
    a_valid = 1'b1; a_sel = 2'd2;
    cycle();
    a_sel = 2'd3;
    cycle();
    a_valid = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    chk("mrst.out_valid", a_out_valid, 1'b0);
    chk("mrst.out_data", a_data, 32'h0);
    chk("mrst.out_sel", a_out_sel, 2'd0);
    chk("mrst.in_ready", a_ready, 1'b1);
    a_out_ready = 1'b1; a_valid = 1'b1; a_sel = 2'd1;
    cycle();
    a_valid = 1'b0;
    chk("mrst.first_data", a_data, 32'hBBBB_0001);
    cycle();

    // Randomized traffic against the FIFO model
    for (int i = 0; i < 400; i++) begin
      bus         = {$urandom, $urandom, $urandom, $urandom};
      a_valid     = 1'($urandom_range(0, 1));
      a_sel       = 2'($urandom_range(0, 3));
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_valid     = 1'($urandom_range(0, 1));
      b_sel       = 2'($urandom_range(0, 3));
      b_out_ready = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 31) == 0);
      cycle();
    end
    flush = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_mux_nto1_skid
`default_nettype wire
